// File: rtl/alu_trace_recorder_pkg.sv
// Shared definitions for the ALU trace recorder: record layout, recorder states, ALU opcodes.
// Record layout matches the alu_data.mem vector format bit-for-bit.
// No logic here; types and constants only.
package alu_trace_recorder_pkg;

  // Record width and field positions {a, b, out, op, flags}
  localparam int ALU_REC_W     = 35;
  localparam int REC_A_MSB     = 34;
  localparam int REC_A_LSB     = 27;
  localparam int REC_B_MSB     = 26;
  localparam int REC_B_LSB     = 19;
  localparam int REC_OUT_MSB   = 18;
  localparam int REC_OUT_LSB   = 11;
  localparam int REC_OP_MSB    = 10;
  localparam int REC_OP_LSB    = 8;
  localparam int REC_FLAGS_MSB = 7;
  localparam int REC_FLAGS_LSB = 0;

  // Recorder control states
  typedef enum logic [1:0] {
    TR_IDLE = 2'd0,
    TR_RUN  = 2'd1,
    TR_HALT = 2'd2
  } tr_state_e;

  // ALU opcodes as seen on the op field of a record
  localparam logic [2:0] ALU_OP_ADD = 3'd0;
  localparam logic [2:0] ALU_OP_SUB = 3'd1;
  localparam logic [2:0] ALU_OP_AND = 3'd2;
  localparam logic [2:0] ALU_OP_OR  = 3'd3;
  localparam logic [2:0] ALU_OP_XOR = 3'd4;
  localparam logic [2:0] ALU_OP_NOT = 3'd5;
  localparam logic [2:0] ALU_OP_SHL = 3'd6;
  localparam logic [2:0] ALU_OP_SHR = 3'd7;

  // One captured transaction, MSB-first in the same order as the vector file
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic [2:0] op;
    logic [7:0] flags;
  } alu_rec_t;

endpackage

// File: rtl/alu_trace_recorder_mem.sv
// Record storage for the trace recorder: DEPTH x 35 register array.
// Write lands on the clock edge; read is combinational from rd_addr (zero latency).
// No flow control here; the owner decides when wr_en is asserted.
module trace_buf_mem
  import alu_trace_recorder_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  alu_rec_t          wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output alu_rec_t          rd_data
);

  alu_rec_t mem_q [DEPTH];

  // Single synchronous write port; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/alu_trace_recorder.sv
// Captures ALU transactions into a circular record buffer, drained first-word fall-through.
// Latency: a captured record is visible on rd_data the cycle after capture.
// Backpressure: rd_ready stalls draining; when full, new records are dropped or overwrite the oldest.
module alu_trace_recorder
  import alu_trace_recorder_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter bit WRAP_MODE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clr,
  input  logic                 cap_valid,
  input  logic [7:0]           a,
  input  logic [7:0]           b,
  input  logic [7:0]           out,
  input  logic [2:0]           op,
  input  logic [7:0]           flags,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [ALU_REC_W-1:0] rd_data,
  output logic [ADDR_W:0]      count,
  output logic                 full,
  output logic                 overflow,
  output logic [7:0]           dropped,
  output logic                 running
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  tr_state_e         state_q, state_d;
  logic              running_q, running_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        dropped_q, dropped_d;

  logic     push, pop, is_full, mem_we;
  alu_rec_t wr_rec, rd_rec;

  assign wr_rec = {a, b, out, op, flags};

  // Next-state for the control FSM; stop dominates start, and IDLE ignores stop
  always_comb begin
    state_d = state_q;
    case (state_q)
      TR_IDLE: if (start && !stop) state_d = TR_RUN;
      TR_RUN:  if (stop)           state_d = TR_HALT;
      TR_HALT: if (start && !stop) state_d = TR_RUN;
      default:                     state_d = TR_IDLE;
    endcase
    running_d = (state_d == TR_RUN);
  end

  // Pointer, occupancy and loss accounting; clr wipes the buffer and masks push/pop
  always_comb begin
    push       = cap_valid && (state_q == TR_RUN);
    is_full    = (count_q == DEPTH_C);
    pop        = (count_q != '0) && rd_ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    dropped_d  = dropped_q;
    mem_we     = 1'b0;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      dropped_d  = '0;
    end else if (push && pop) begin
      // Even when full the popped slot is the one being refilled: no loss
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      count_d  = count_q - (ADDR_W+1)'(1);
    end else if (push) begin
      if (!is_full) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        count_d  = count_q + (ADDR_W+1)'(1);
      end else begin
        overflow_d = 1'b1;
        if (dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
        if (WRAP_MODE) begin
          // Overwrite the oldest: both pointers step, occupancy stays DEPTH
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
      end
    end
  end

  // All recorder state, with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TR_IDLE;
      running_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      state_q    <= state_d;
      running_q  <= running_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

  trace_buf_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we && !rst),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_rec),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_rec)
  );

  // rd_valid depends only on registered occupancy, never on rd_ready
  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_rec;
  assign count    = count_q;
  assign full     = (count_q == DEPTH_C);
  assign overflow = overflow_q;
  assign dropped  = dropped_q;
  assign running  = running_q;

endmodule
